// File: rtl/rsa_job_scheduler_if.sv
// Bundle of the requester, core and response signals around rsa_job_scheduler.
// master = scheduler side, slave = requesters, exponentiate core and result consumer.
interface rsa_job_scheduler_if #(
    parameter int RSA_WIDTH = 128,
    parameter int NUM_REQ   = 2,
    parameter int ID_W      = 1
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*RSA_WIDTH-1:0] req_m;
    logic [NUM_REQ*RSA_WIDTH-1:0] req_e;
    logic [NUM_REQ*RSA_WIDTH-1:0] req_n;
    logic                         core_start;
    logic [RSA_WIDTH-1:0]         core_m;
    logic [RSA_WIDTH-1:0]         core_e;
    logic [RSA_WIDTH-1:0]         core_n;
    logic [RSA_WIDTH-1:0]         core_c;
    logic                         core_ready;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_W-1:0]              rsp_id;
    logic [RSA_WIDTH-1:0]         rsp_c;
    logic                         rsp_err;
    logic                         busy;

    modport master (
        input  req_valid, req_m, req_e, req_n, core_c, core_ready, rsp_ready,
        output req_ready, core_start, core_m, core_e, core_n,
               rsp_valid, rsp_id, rsp_c, rsp_err, busy
    );

    modport slave (
        output req_valid, req_m, req_e, req_n, core_c, core_ready, rsp_ready,
        input  req_ready, core_start, core_m, core_e, core_n,
               rsp_valid, rsp_id, rsp_c, rsp_err, busy
    );
endinterface

// File: rtl/rsa_job_scheduler.sv
// Round-robin sharing of one modular-exponentiation core among NUM_REQ requesters.
// Optional BUSY watchdog with error response is built when RSA_TIMEOUT_EN is defined.
module rsa_job_scheduler #(
    parameter int RSA_WIDTH      = 128,
    parameter int NUM_REQ        = 2,
    parameter int ID_W           = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    rsa_job_scheduler_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_BUSY,
        S_RESP
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < $clog2(NUM_REQ) || TIMEOUT_CYCLES < 3) begin : g_bad_params
        $error("rsa_job_scheduler: illegal parameter combination");
    end

    state_t               r_state;
    logic [ID_W-1:0]      r_rr_ptr;
    logic                 r_core_start;
    logic [RSA_WIDTH-1:0] r_core_m;
    logic [RSA_WIDTH-1:0] r_core_e;
    logic [RSA_WIDTH-1:0] r_core_n;
    logic                 r_rsp_valid;
    logic [ID_W-1:0]      r_rsp_id;
    logic [RSA_WIDTH-1:0] r_rsp_c;
    logic                 r_busy;

    logic [NUM_REQ-1:0]   w_vld_rot;
    logic                 w_gnt_vld;
    int                   w_gnt_int;
    logic [ID_W-1:0]      w_ptr_nxt;
    logic [RSA_WIDTH-1:0] w_m_sel;
    logic [RSA_WIDTH-1:0] w_e_sel;
    logic [RSA_WIDTH-1:0] w_n_sel;

`ifdef RSA_TIMEOUT_EN
    // ISSUE and ARM count toward the limit, so the abort lands TIMEOUT_CYCLES+1 cycles after core_start
    localparam logic [31:0] LP_WD_LAST = 32'(TIMEOUT_CYCLES - 2);
    logic        r_rsp_err;
    logic [31:0] r_wd_cnt;
`endif

    // Rotate so bit k is requester (rr_ptr + k); lowest set bit wins
    always_comb begin
        w_vld_rot = (bus.req_valid >> r_rr_ptr) | (bus.req_valid << (NUM_REQ - int'(r_rr_ptr)));
        w_gnt_vld = 1'b0;
        w_gnt_int = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_vld_rot[k]) begin
                w_gnt_vld = 1'b1;
                w_gnt_int = (int'(r_rr_ptr) + k) % NUM_REQ;
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_int == NUM_REQ - 1) ? '0 : ID_W'(w_gnt_int + 1);
    assign w_m_sel   = RSA_WIDTH'(bus.req_m >> (w_gnt_int * RSA_WIDTH));
    assign w_e_sel   = RSA_WIDTH'(bus.req_e >> (w_gnt_int * RSA_WIDTH));
    assign w_n_sel   = RSA_WIDTH'(bus.req_n >> (w_gnt_int * RSA_WIDTH));

    always_comb begin
        bus.req_ready = '0;
        if (r_state == S_IDLE && w_gnt_vld && !reset) begin
            bus.req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_int;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_core_start <= 1'b0;
            r_core_m     <= '0;
            r_core_e     <= '0;
            r_core_n     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_c      <= '0;
            r_busy       <= 1'b0;
`ifdef RSA_TIMEOUT_EN
            r_rsp_err    <= 1'b0;
            r_wd_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_core_m     <= w_m_sel;
                        r_core_e     <= w_e_sel;
                        r_core_n     <= w_n_sel;
                        r_rsp_id     <= ID_W'(w_gnt_int);
                        r_rr_ptr     <= w_ptr_nxt;
                        r_core_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_core_start <= 1'b0;
                    r_state      <= S_ARM;
                end
                // core_ready is ignored here: it may still be left over from the previous job
                S_ARM: begin
`ifdef RSA_TIMEOUT_EN
                    r_wd_cnt <= '0;
`endif
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    if (bus.core_ready) begin
                        r_rsp_c     <= bus.core_c;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
`ifdef RSA_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                    end
`ifdef RSA_TIMEOUT_EN
                    else if (r_wd_cnt == LP_WD_LAST) begin
                        r_rsp_c     <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 32'd1;
                    end
`endif
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.core_start = r_core_start;
    assign bus.core_m     = r_core_m;
    assign bus.core_e     = r_core_e;
    assign bus.core_n     = r_core_n;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_c      = r_rsp_c;
    assign bus.busy       = r_busy;
`ifdef RSA_TIMEOUT_EN
    assign bus.rsp_err    = r_rsp_err;
`else
    assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Scoreboard bench for rsa_job_scheduler with a behavioural exponentiate core.
// Define RSA_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_rsa_job_scheduler;

    localparam int RW  = 128;
    localparam int NR  = 2;
    localparam int IW  = 1;
    localparam int TMO = 50;

    logic clk;
    logic reset;

    rsa_job_scheduler_if #(.RSA_WIDTH(RW), .NUM_REQ(NR), .ID_W(IW)) bus ();

    rsa_job_scheduler #(
        .RSA_WIDTH(RW), .NUM_REQ(NR), .ID_W(IW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int cyc     = 0;
    int core_mode = 0;   // 0 normal, 1 stale ready held through ISSUE/ARM, 2 never ready

    int            sb_id[$];
    logic [RW-1:0] sb_c[$];

    logic [RW-1:0] cm_res;
    int            cm_cnt;
    logic          cm_run;
    logic          cm_hold;
    logic          cm_rose;

    function automatic logic [RW-1:0] modexp(input logic [RW-1:0] m, input logic [RW-1:0] e,
                                             input logic [RW-1:0] n);
        logic [2*RW-1:0] r, b, nn;
        nn = {{RW{1'b0}}, n};
        r  = {{(2*RW-1){1'b0}}, 1'b1};
        b  = {{RW{1'b0}}, m} % nn;
        for (int i = 0; i < RW; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[RW-1:0];
    endfunction

    // Behavioural core: result CORE latency cycles after start, ready held until next start
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.core_ready <= 1'b0;
            bus.core_c     <= '0;
            cm_run         <= 1'b0;
            cm_hold        <= 1'b0;
            cm_rose        <= 1'b0;
            cm_cnt         <= 0;
        end else if (bus.core_start) begin
            cm_res  <= modexp(bus.core_m, bus.core_e, bus.core_n);
            cm_cnt  <= 5;
            cm_run  <= (core_mode != 2);
            cm_hold <= (core_mode == 1);
            cm_rose <= 1'b0;
            if (core_mode != 1) bus.core_ready <= 1'b0;
        end else if (cm_hold) begin
            bus.core_ready <= 1'b0;
            cm_hold        <= 1'b0;
        end else if (cm_run) begin
            if (cm_cnt == 0) begin
                bus.core_ready <= 1'b1;
                bus.core_c     <= cm_res;
                cm_run         <= 1'b0;
                cm_rose        <= 1'b1;
            end else begin
                cm_cnt <= cm_cnt - 1;
            end
        end
    end

    // Scoreboard push on every accepted request
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.core_start) n_start <= n_start + 1;
        for (int i = 0; i < NR; i++) begin
            if (bus.req_ready[i]) begin
                sb_id.push_back(i);
                sb_c.push_back(modexp(bus.req_m[i*RW +: RW], bus.req_e[i*RW +: RW], bus.req_n[i*RW +: RW]));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "bench watchdog");
    end

    task automatic set_slot(input int i, input logic [RW-1:0] m, input logic [RW-1:0] e,
                            input logic [RW-1:0] n);
        bus.req_m[i*RW +: RW] = m;
        bus.req_e[i*RW +: RW] = e;
        bus.req_n[i*RW +: RW] = n;
    endtask

    task automatic wait_accept(input int budget, output bit got);
        got = 1'b0;
        #1;
        for (int i = 0; i < budget; i++) begin
            if (bus.req_ready != '0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic pop_exp(output int id, output logic [RW-1:0] c, output bit ok);
        ok = (sb_id.size() != 0);
        id = -1;
        c  = '0;
        if (ok) begin
            id = sb_id.pop_front();
            c  = sb_c.pop_front();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_slot(0, 4, 13, 497);
        set_slot(1, 5, 3, 7);
        bus.req_valid = 2'b11;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
        n_tests++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.core_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: busy/rsp_valid/core_start got %b%b%b want 000", bus.busy, bus.rsp_valid, bus.core_start);
        end
        n_tests++;
        if (bus.core_m !== '0 || bus.core_e !== '0 || bus.core_n !== '0) begin
            n_fail++; $display("FAIL reset_core_ops: core_m %0d core_e %0d core_n %0d want 0", bus.core_m, bus.core_e, bus.core_n);
        end
        n_tests++;
        if (bus.rsp_c !== '0 || bus.rsp_id !== '0 || bus.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp: rsp_c %0d rsp_id %0d rsp_err %b want 0", bus.rsp_c, bus.rsp_id, bus.rsp_err);
        end
        bus.req_valid = 2'b00;
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle: busy %b req_ready %b want 0 00", bus.busy, bus.req_ready);
        end
    endtask

    task automatic test_single();
        bit got, ok;
        int eid, s0;
        logic [RW-1:0] ec;
        bus.rsp_ready = 1'b1;
        set_slot(0, 4, 13, 497);
        bus.req_valid = 2'b01;
        s0 = n_start;
        wait_accept(20, got);
        n_tests++;
        if (!got || bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL t1_accept: req_ready %b want 01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00;
        n_tests++;
        if (bus.core_start !== 1'b1) begin n_fail++; $display("FAIL t1_start_latency: core_start %b want 1", bus.core_start); end
        @(negedge clk);
        n_tests++;
        if (bus.core_start !== 1'b0) begin n_fail++; $display("FAIL t1_start_pulse: core_start %b want 0", bus.core_start); end
        wait_rsp(100, got);
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL t1_rsp_wait: rsp_valid %b want 1", bus.rsp_valid); end
        pop_exp(eid, ec, ok);
        n_tests++;
        if (!ok || bus.rsp_id !== IW'(eid) || bus.rsp_c !== ec) begin
            n_fail++; $display("FAIL t1_rsp: id %0d c %0d want id %0d c %0d", bus.rsp_id, bus.rsp_c, eid, ec);
        end
        n_tests++;
        if (bus.rsp_c !== 128'd445 || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL t1_value: c %0d id %0d err %b want 445 0 0", bus.rsp_c, bus.rsp_id, bus.rsp_err);
        end
        n_tests++;
        if (n_start - s0 != 1) begin n_fail++; $display("FAIL t1_start_count: got %0d want 1", n_start - s0); end
        @(negedge clk);
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL t1_done: rsp_valid %b busy %b want 0 0", bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_round_robin();
        bit got, ok;
        int eid;
        logic [RW-1:0] ec;
        int            exp_id[4] = '{0, 1, 0, 1};
        logic [RW-1:0] exp_c[4]  = '{128'd6, 128'd445, 128'd6, 128'd445};
        logic [1:0]    exp_rdy;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_slot(0, 5, 3, 7);
        set_slot(1, 4, 13, 497);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(100, got);
            if (k == 3) bus.req_valid = 2'b00;
            n_tests++;
            if (!got) begin n_fail++; $display("FAIL t2_rsp_wait[%0d]: rsp_valid %b want 1", k, bus.rsp_valid); end
            pop_exp(eid, ec, ok);
            n_tests++;
            if (!ok || bus.rsp_id !== IW'(exp_id[k]) || eid != exp_id[k] || bus.rsp_c !== exp_c[k] || bus.rsp_c !== ec) begin
                n_fail++; $display("FAIL t2_rr[%0d]: id %0d c %0d want id %0d c %0d", k, bus.rsp_id, bus.rsp_c, exp_id[k], exp_c[k]);
            end
            @(negedge clk);
            if (k < 3) begin
                exp_rdy = (exp_id[k+1] == 0) ? 2'b01 : 2'b10;
                n_tests++;
                if (bus.busy !== 1'b0 || bus.req_ready !== exp_rdy) begin
                    n_fail++; $display("FAIL t2_idle_gap[%0d]: busy %b req_ready %b want 0 %b", k, bus.busy, bus.req_ready, exp_rdy);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit got, ok;
        int eid, s0;
        logic [RW-1:0] ec;
        bus.rsp_ready = 1'b0;
        set_slot(0, 5, 3, 7);
        bus.req_valid = 2'b11;
        wait_rsp(100, got);
        n_tests++;
        if (!got || sb_id.size() == 0) begin
            n_fail++; $display("FAIL t3_rsp_wait: rsp_valid %b queued %0d want 1 1", bus.rsp_valid, sb_id.size());
        end else begin
            s0 = n_start;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                n_tests++;
                if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 2'b00 || bus.busy !== 1'b1 ||
                    bus.rsp_id !== IW'(sb_id[0]) || bus.rsp_c !== sb_c[0]) begin
                    n_fail++; $display("FAIL t3_hold[%0d]: valid %b rdy %b id %0d c %0d want 1 00 %0d %0d",
                                       i, bus.rsp_valid, bus.req_ready, bus.rsp_id, bus.rsp_c, sb_id[0], sb_c[0]);
                end
            end
            n_tests++;
            if (n_start != s0) begin n_fail++; $display("FAIL t3_no_restart: extra starts %0d want 0", n_start - s0); end
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        pop_exp(eid, ec, ok);
        n_tests++;
        if (!ok || eid != 0 || bus.rsp_id !== 1'b0 || bus.rsp_c !== 128'd6 || ec !== 128'd6) begin
            n_fail++; $display("FAIL t3_rsp: id %0d c %0d want id 0 c 6", bus.rsp_id, bus.rsp_c);
        end
        @(negedge clk);
    endtask

    task automatic test_stale();
        bit got, ok, rose;
        int eid;
        logic [RW-1:0] ec;
        core_mode = 1;
        set_slot(1, 7, 5, 11);
        bus.req_valid = 2'b10;
        wait_accept(20, got);
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL t4_accept: req_ready %b want 10", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00;
        got  = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                got  = 1'b1;
                rose = cm_rose;
                break;
            end
        end
        n_tests++;
        if (!got || !rose) begin n_fail++; $display("FAIL t4_early: rsp_valid %b after_new_ready %b want 1 1", got, rose); end
        pop_exp(eid, ec, ok);
        n_tests++;
        if (!ok || bus.rsp_id !== IW'(eid) || bus.rsp_c !== ec || bus.rsp_c !== 128'd10) begin
            n_fail++; $display("FAIL t4_rsp: id %0d c %0d want id 1 c 10", bus.rsp_id, bus.rsp_c);
        end
        @(negedge clk);
        core_mode = 0;
    endtask

    task automatic test_reset_mid();
        bit got, ok, seen;
        int eid;
        logic [RW-1:0] ec;
        core_mode = 2;
        set_slot(0, 4, 13, 497);
        bus.req_valid = 2'b01;
        wait_accept(20, got);
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (12) @(negedge clk);
        n_tests++;
        if (!got || bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL t5_in_busy: busy %b rsp_valid %b want 1 0", bus.busy, bus.rsp_valid);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.core_start !== 1'b0 ||
            bus.core_m !== '0 || bus.rsp_c !== '0 || bus.rsp_id !== '0) begin
            n_fail++; $display("FAIL t5_async_clear: busy %b valid %b core_m %0d rsp_c %0d want 0 0 0 0",
                               bus.busy, bus.rsp_valid, bus.core_m, bus.rsp_c);
        end
        pop_exp(eid, ec, ok);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL t5_discard: rsp_valid seen %b want 0", seen); end
        core_mode = 0;
        set_slot(1, 5, 3, 7);
        bus.req_valid = 2'b10;
        wait_accept(20, got);
        @(negedge clk);
        bus.req_valid = 2'b00;
        wait_rsp(100, got);
        pop_exp(eid, ec, ok);
        n_tests++;
        if (!got || !ok || bus.rsp_id !== 1'b1 || bus.rsp_c !== 128'd6 || bus.rsp_c !== ec || eid != 1) begin
            n_fail++; $display("FAIL t5_recover: valid %b id %0d c %0d want 1 1 6", got, bus.rsp_id, bus.rsp_c);
        end
        @(negedge clk);
    endtask

`ifdef RSA_TIMEOUT_EN
    task automatic test_timeout();
        bit got, ok;
        int eid, s0, r0;
        logic [RW-1:0] ec;
        core_mode = 2;
        set_slot(0, 4, 13, 497);
        bus.req_valid = 2'b01;
        wait_accept(20, got);
        @(negedge clk);
        s0 = cyc;
        bus.req_valid = 2'b00;
        n_tests++;
        if (!got || bus.core_start !== 1'b1) begin n_fail++; $display("FAIL t6_start: core_start %b want 1", bus.core_start); end
        wait_rsp(200, got);
        r0 = cyc;
        n_tests++;
        if (!got || r0 - s0 != TMO + 1) begin
            n_fail++; $display("FAIL t6_latency: rsp after %0d cycles want %0d", r0 - s0, TMO + 1);
        end
        pop_exp(eid, ec, ok);
        n_tests++;
        if (!ok || bus.rsp_err !== 1'b1 || bus.rsp_c !== '0 || bus.rsp_id !== IW'(eid)) begin
            n_fail++; $display("FAIL t6_abort: err %b c %0d id %0d want 1 0 %0d", bus.rsp_err, bus.rsp_c, bus.rsp_id, eid);
        end
        @(negedge clk);
        core_mode = 0;
    endtask
`endif

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_m     = '0;
        bus.req_e     = '0;
        bus.req_n     = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_stale();
        test_reset_mid();
`ifdef RSA_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
